rob: RTL and testbench

Reorder buffer for the out-of-order core: a circular buffer of in-flight instructions, allocated in program order at dispatch, marked complete by functional-unit writeback, and retired in order one per cycle. It sits between dispatch/rename (upstream) and the reservation stations and functional units (downstream). Its commit port supplies RVFI retirement data and the renamed `rat` fields that free-list and RAT update logic consume.

---
 rtl/rob_pkg.sv | 59 +++++
 rtl/rob.sv | 116 +++++++++++
 tb/tb_rob.sv | 354 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rob_pkg.sv
// Shared RV32I pipeline types for the reorder buffer: dispatch payload, writeback bus and ROB slot.
// The rob_id field stays 8 bits wide regardless of ROB depth.
package rv32i_types;

    localparam int unsigned ROB_DEPTH = 16;
    localparam int unsigned ROB_ID_W  = 8;

    typedef struct packed {
        logic        valid;
        logic [63:0] order;
        logic [31:0] inst;
        logic [4:0]  rs1_addr;
        logic [4:0]  rs2_addr;
        logic [31:0] rs1_rdata;
        logic [31:0] rs2_rdata;
        logic [4:0]  rd_addr;
        logic [31:0] rd_wdata;
        logic [31:0] pc_rdata;
        logic [31:0] pc_wdata;
        logic [31:0] mem_addr;
        logic [3:0]  mem_rmask;
        logic [3:0]  mem_wmask;
        logic [31:0] mem_rdata;
        logic [31:0] mem_wdata;
    } rvfi_t;

    typedef struct packed {
        logic [4:0] rd_arch;
        logic [5:0] rd_phys;
        logic [5:0] rd_phys_old;
    } rat_t;

    typedef struct packed {
        logic [ROB_ID_W-1:0] rob_id;
    } rob_info_t;

    typedef struct packed {
        rvfi_t     rvfi;
        rat_t      rat;
        rob_info_t rob;
    } dispatch_reservation_t;

    typedef struct packed {
        dispatch_reservation_t reservation_entry;
    } inst_info_t;

    typedef struct packed {
        logic        ready_for_writeback;
        logic [31:0] register_value;
        inst_info_t  inst_info;
    } fu_output_t;

    typedef struct packed {
        dispatch_reservation_t entry;
        logic                  valid;
        logic                  done;
    } rob_slot_t;

endpackage

// File: rtl/rob.sv
// Reorder buffer: in-order allocation at dispatch, out-of-order completion from writeback,
// in-order retirement of at most one entry per cycle through a registered commit port.
module rob
    import rv32i_types::*;
#(
    parameter int unsigned ROB_DEPTH = rv32i_types::ROB_DEPTH
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      flush,
    input  logic                      dispatch_valid,
    input  dispatch_reservation_t     dispatch_entry,
    output logic                      dispatch_ready,
    output logic [ROB_ID_W-1:0]       dispatch_rob_id,
    input  fu_output_t                fu_result,
    output logic                      commit_valid,
    output dispatch_reservation_t     commit_entry,
    output logic [ROB_ID_W-1:0]       head_rob_id,
    output logic [$clog2(ROB_DEPTH):0] count
);

    localparam int unsigned IDX_W = $clog2(ROB_DEPTH);
    localparam int unsigned PTR_W = IDX_W + 1;

    logic [PTR_W-1:0]      head_q, head_d;
    logic [PTR_W-1:0]      tail_q, tail_d;
    rob_slot_t             slots_q [ROB_DEPTH];
    rob_slot_t             slots_d [ROB_DEPTH];
    logic                  commit_valid_q, commit_valid_d;
    dispatch_reservation_t commit_entry_q, commit_entry_d;

    logic [IDX_W-1:0] head_idx;
    logic [IDX_W-1:0] tail_idx;
    logic [IDX_W-1:0] wb_idx;
    logic             full;
    logic             unused_fu;

    assign head_idx = head_q[IDX_W-1:0];
    assign tail_idx = tail_q[IDX_W-1:0];
    assign wb_idx   = fu_result.inst_info.reservation_entry.rob.rob_id[IDX_W-1:0];

    // Only the writeback target index and value are consumed from the FU bus.
    assign unused_fu = ^fu_result;

    // Wrap bit distinguishes full from empty when the index bits match.
    assign full = (head_idx == tail_idx) && (head_q[IDX_W] != tail_q[IDX_W]);

    assign dispatch_ready  = rst && !full;
    assign dispatch_rob_id = ROB_ID_W'(tail_idx);
    assign head_rob_id     = ROB_ID_W'(head_idx);
    assign count           = tail_q - head_q;
    assign commit_valid    = commit_valid_q;
    assign commit_entry    = commit_entry_q;

    always_comb begin
        slots_d        = slots_q;
        head_d         = head_q;
        tail_d         = tail_q;
        commit_valid_d = 1'b0;
        commit_entry_d = commit_entry_q;

        if (flush) begin
            for (int i = 0; i < int'(ROB_DEPTH); i++) begin
                slots_d[i].valid = 1'b0;
                slots_d[i].done  = 1'b0;
            end
            head_d = '0;
            tail_d = '0;
        end else begin
            if (fu_result.ready_for_writeback && slots_q[wb_idx].valid) begin
                slots_d[wb_idx].done = 1'b1;
                slots_d[wb_idx].entry.rvfi.rd_wdata =
                    (slots_q[wb_idx].entry.rvfi.rd_addr == 5'd0) ? 32'd0
                                                                 : fu_result.register_value;
            end

            // Commit sees pre-edge state, so a same-cycle writeback to the head is not bypassed.
            // Applied after writeback so the slot clear wins on the retiring entry.
            if (slots_q[head_idx].valid && slots_q[head_idx].done) begin
                commit_entry_d            = slots_q[head_idx].entry;
                commit_entry_d.rvfi.valid = 1'b1;
                commit_valid_d            = 1'b1;
                slots_d[head_idx].valid   = 1'b0;
                slots_d[head_idx].done    = 1'b0;
                head_d                    = head_q + PTR_W'(1);
            end

            if (dispatch_valid && dispatch_ready) begin
                slots_d[tail_idx].entry            = dispatch_entry;
                slots_d[tail_idx].entry.rob.rob_id = ROB_ID_W'(tail_idx);
                slots_d[tail_idx].valid            = 1'b1;
                slots_d[tail_idx].done             = 1'b0;
                tail_d                             = tail_q + PTR_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            head_q         <= '0;
            tail_q         <= '0;
            commit_valid_q <= 1'b0;
            commit_entry_q <= '0;
            for (int i = 0; i < int'(ROB_DEPTH); i++) begin
                slots_q[i] <= '0;
            end
        end else begin
            head_q         <= head_d;
            tail_q         <= tail_d;
            commit_valid_q <= commit_valid_d;
            commit_entry_q <= commit_entry_d;
            slots_q        <= slots_d;
        end
    end

endmodule

// File: tb/tb_rob.sv
// Self-checking bench for rob: a queue-based reference model checked every cycle, plus
// directed scenarios with hand-computed literal expectations.
module tb_rob;
    import rv32i_types::*;

    localparam int DEPTH = 16;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  flush;
    logic                  dispatch_valid;
    dispatch_reservation_t dispatch_entry;
    logic                  dispatch_ready;
    logic [7:0]            dispatch_rob_id;
    fu_output_t            fu_result;
    logic                  commit_valid;
    dispatch_reservation_t commit_entry;
    logic [7:0]            head_rob_id;
    logic [4:0]            count;

    always #5 clk = ~clk;

    rob #(.ROB_DEPTH(DEPTH)) dut (
        .clk             (clk),
        .rst             (rst),
        .flush           (flush),
        .dispatch_valid  (dispatch_valid),
        .dispatch_entry  (dispatch_entry),
        .dispatch_ready  (dispatch_ready),
        .dispatch_rob_id (dispatch_rob_id),
        .fu_result       (fu_result),
        .commit_valid    (commit_valid),
        .commit_entry    (commit_entry),
        .head_rob_id     (head_rob_id),
        .count           (count)
    );

    int tests = 0;
    int fails = 0;
    bit check_en = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_entry(input string name, input dispatch_reservation_t act,
                             input dispatch_reservation_t exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: in-flight instructions as a program-ordered queue.
    typedef struct {
        dispatch_reservation_t e;
        bit                    done;
    } mrec_t;

    mrec_t                 mq[$];
    int                    m_head = 0;
    int                    m_tail = 0;
    logic                  m_cv = 1'b0;
    dispatch_reservation_t m_ce = '0;

    always @(posedge clk) begin
        if (!rst) begin
            mq.delete();
            m_head = 0;
            m_tail = 0;
            m_cv   = 1'b0;
            m_ce   = '0;
        end else if (flush) begin
            mq.delete();
            m_head = 0;
            m_tail = 0;
            m_cv   = 1'b0;
        end else begin
            bit                    can_disp;
            bit                    do_commit;
            dispatch_reservation_t head_e;
            mrec_t                 r;
            int                    wid;
            can_disp  = mq.size() < DEPTH;
            do_commit = (mq.size() > 0) && mq[0].done;
            head_e    = '0;
            if (do_commit) head_e = mq[0].e;
            if (fu_result.ready_for_writeback) begin
                wid = int'(fu_result.inst_info.reservation_entry.rob.rob_id) % DEPTH;
                foreach (mq[i]) begin
                    if (int'(mq[i].e.rob.rob_id) == wid) begin
                        mq[i].done = 1'b1;
                        mq[i].e.rvfi.rd_wdata = (mq[i].e.rvfi.rd_addr == 5'd0) ? 32'd0
                                                : fu_result.register_value;
                    end
                end
            end
            if (do_commit) begin
                m_ce = head_e;
                m_ce.rvfi.valid = 1'b1;
                void'(mq.pop_front());
                m_head = (m_head + 1) % DEPTH;
                m_cv   = 1'b1;
            end else begin
                m_cv = 1'b0;
            end
            if (dispatch_valid && can_disp) begin
                r.e = dispatch_entry;
                r.e.rob.rob_id = 8'(m_tail);
                r.done = 1'b0;
                mq.push_back(r);
                m_tail = (m_tail + 1) % DEPTH;
            end
        end
    end

    logic [63:0] last_order;
    bit          have_last = 1'b0;

    always @(negedge clk) begin
        if (check_en) begin
            chk("count", 64'(count), 64'(mq.size()));
            chk("count_bound", 64'(count <= DEPTH), 64'd1);
            chk("head_rob_id", 64'(head_rob_id), 64'(m_head));
            chk("dispatch_rob_id", 64'(dispatch_rob_id), 64'(m_tail));
            chk("dispatch_ready", 64'(dispatch_ready), 64'(rst && (mq.size() < DEPTH)));
            chk("commit_valid", 64'(commit_valid), 64'(m_cv));
            chk_entry("commit_entry", commit_entry, m_ce);
            if (commit_valid === 1'b1) begin
                if (have_last)
                    chk("order_increasing", 64'(commit_entry.rvfi.order > last_order), 64'd1);
                last_order = commit_entry.rvfi.order;
                have_last  = 1'b1;
            end
        end
    end

    function automatic dispatch_reservation_t mk_entry(input int ord, input logic [4:0] rd);
        dispatch_reservation_t e;
        e = '0;
        e.rvfi.order       = 64'(ord);
        e.rvfi.inst        = 32'h0000_0013 ^ 32'(ord << 12);
        e.rvfi.rs1_addr    = 5'(ord + 3);
        e.rvfi.rs2_addr    = 5'(ord + 7);
        e.rvfi.rd_addr     = rd;
        e.rvfi.rd_wdata    = 32'h5A5A_5A5A;
        e.rvfi.pc_rdata    = 32'h1000 + 32'(ord * 4);
        e.rvfi.pc_wdata    = 32'h1004 + 32'(ord * 4);
        e.rvfi.mem_addr    = 32'(ord * 16);
        e.rvfi.mem_wmask   = 4'(ord);
        e.rat.rd_arch      = rd;
        e.rat.rd_phys      = 6'(ord + 32);
        e.rat.rd_phys_old  = 6'(ord);
        e.rob.rob_id       = 8'hEE;
        return e;
    endfunction

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic do_dispatch(input int ord, input logic [4:0] rd);
        dispatch_valid = 1'b1;
        dispatch_entry = mk_entry(ord, rd);
        tick();
        dispatch_valid = 1'b0;
    endtask

    task automatic set_wb(input int id, input logic [31:0] val);
        fu_result = '0;
        fu_result.ready_for_writeback = 1'b1;
        fu_result.register_value = val;
        fu_result.inst_info.reservation_entry.rob.rob_id = 8'(id);
    endtask

    task automatic do_wb(input int id, input logic [31:0] val);
        set_wb(id, val);
        tick();
        fu_result.ready_for_writeback = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int pending[$];
        int sent;
        int retired;
        int base;
        int pick;

        rst = 1'b0;
        flush = 1'b0;
        dispatch_valid = 1'b0;
        dispatch_entry = '0;
        fu_result = '0;
        repeat (3) tick();
        check_en = 1'b1;

        // Reset state
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_ready", 64'(dispatch_ready), 64'd0);
        chk("rst_dispatch_id", 64'(dispatch_rob_id), 64'd0);
        chk_entry("rst_commit_entry", commit_entry, '0);
        rst = 1'b1;
        #1;
        chk("ready_after_rst", 64'(dispatch_ready), 64'd1);

        // Fill: ids 0..15, then the 17th offer is refused
        for (int i = 0; i < DEPTH; i++) begin
            chk("fill_id", 64'(dispatch_rob_id), 64'(i));
            do_dispatch(i, 5'(i + 1));
        end
        chk("full_count", 64'(count), 64'd16);
        chk("full_ready", 64'(dispatch_ready), 64'd0);
        do_dispatch(99, 5'd9);
        chk("full_refused_count", 64'(count), 64'd16);

        // Full with simultaneous commit
        do_wb(0, 32'hA0);
        chk("wb_not_yet_committed", 64'(commit_valid), 64'd0);
        chk("full_commit_cycle_ready", 64'(dispatch_ready), 64'd0);
        do_dispatch(98, 5'd9);
        chk("full_commit_valid", 64'(commit_valid), 64'd1);
        chk("full_commit_order", commit_entry.rvfi.order, 64'd0);
        chk("full_commit_wdata", 64'(commit_entry.rvfi.rd_wdata), 64'hA0);
        chk("ready_after_commit", 64'(dispatch_ready), 64'd1);
        chk("freed_id", 64'(dispatch_rob_id), 64'd0);
        do_dispatch(16, 5'd4);
        chk("refill_count", 64'(count), 64'd16);

        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush_count", 64'(count), 64'd0);

        // In-order retire despite out-of-order writeback
        do_dispatch(100, 5'd1);
        do_dispatch(101, 5'd2);
        do_dispatch(102, 5'd3);
        do_wb(2, 32'h22);
        do_wb(1, 32'h11);
        do_wb(0, 32'h00);
        chk("ooo_latency", 64'(commit_valid), 64'd0);
        tick();
        chk("ooo_c0_valid", 64'(commit_valid), 64'd1);
        chk("ooo_c0_order", commit_entry.rvfi.order, 64'd100);
        chk("ooo_c0_wdata", 64'(commit_entry.rvfi.rd_wdata), 64'h00);
        chk("ooo_c0_rvfi_valid", 64'(commit_entry.rvfi.valid), 64'd1);
        tick();
        chk("ooo_c1_order", commit_entry.rvfi.order, 64'd101);
        chk("ooo_c1_wdata", 64'(commit_entry.rvfi.rd_wdata), 64'h11);
        tick();
        chk("ooo_c2_order", commit_entry.rvfi.order, 64'd102);
        chk("ooo_c2_wdata", 64'(commit_entry.rvfi.rd_wdata), 64'h22);
        chk("ooo_c2_rob_id", 64'(commit_entry.rob.rob_id), 64'd2);
        tick();
        chk("ooo_drained", 64'(commit_valid), 64'd0);

        // x0 destination and stale writeback
        chk("x0_id", 64'(dispatch_rob_id), 64'd3);
        do_dispatch(200, 5'd0);
        do_wb(5, 32'hBEEF);
        chk("stale_count", 64'(count), 64'd1);
        chk("stale_no_commit", 64'(commit_valid), 64'd0);
        do_wb(3, 32'hDEAD);
        tick();
        chk("x0_commit_valid", 64'(commit_valid), 64'd1);
        chk("x0_commit_order", commit_entry.rvfi.order, 64'd200);
        chk("x0_wdata", 64'(commit_entry.rvfi.rd_wdata), 64'd0);

        // Sustained traffic through 40 instructions with pointer wrap
        sent = 0;
        retired = 0;
        for (int cyc = 0; cyc < 600 && retired < 40; cyc++) begin
            fu_result.ready_for_writeback = 1'b0;
            if (pending.size() > 0 && (cyc % 4) != 3) begin
                pick = (cyc % 2 == 1) ? pending.size() - 1 : 0;
                set_wb(pending[pick], 32'(cyc * 3 + 1));
                pending.delete(pick);
            end
            dispatch_valid = 1'b0;
            if (sent < 40 && mq.size() < DEPTH) begin
                dispatch_valid = 1'b1;
                dispatch_entry = mk_entry(300 + sent, 5'((sent % 7) + 1));
                pending.push_back(m_tail);
                sent++;
            end
            tick();
            if (commit_valid === 1'b1) retired++;
        end
        dispatch_valid = 1'b0;
        fu_result.ready_for_writeback = 1'b0;
        chk("wrap_retired", 64'(retired), 64'd40);
        chk("wrap_empty", 64'(count), 64'd0);

        // Flush with dispatch and writeback in the same cycle
        base = m_tail;
        for (int i = 0; i < 5; i++) do_dispatch(500 + i, 5'd6);
        do_wb((base + 2) % DEPTH, 32'h2);
        do_wb((base + 3) % DEPTH, 32'h3);
        chk("pre_flush_count", 64'(count), 64'd5);
        flush = 1'b1;
        dispatch_valid = 1'b1;
        dispatch_entry = mk_entry(505, 5'd6);
        set_wb(base, 32'h1);
        tick();
        flush = 1'b0;
        dispatch_valid = 1'b0;
        fu_result.ready_for_writeback = 1'b0;
        chk("flush_mid_count", 64'(count), 64'd0);
        chk("flush_mid_cv", 64'(commit_valid), 64'd0);
        do_wb(base, 32'h1);
        do_wb((base + 1) % DEPTH, 32'h1);
        repeat (3) tick();
        chk("flush_no_late_commit", 64'(commit_valid), 64'd0);

        // Reset mid-operation clears commit_entry
        for (int i = 0; i < 5; i++) do_dispatch(600 + i, 5'd8);
        do_wb(0, 32'h66);
        tick();
        chk("pre_rst_cv", 64'(commit_valid), 64'd1);
        chk("pre_rst_order", commit_entry.rvfi.order, 64'd600);
        rst = 1'b0;
        dispatch_valid = 1'b1;
        dispatch_entry = mk_entry(605, 5'd8);
        set_wb(1, 32'h77);
        tick();
        dispatch_valid = 1'b0;
        fu_result.ready_for_writeback = 1'b0;
        chk_entry("rst_mid_commit_entry", commit_entry, '0);
        chk("rst_mid_cv", 64'(commit_valid), 64'd0);
        chk("rst_mid_count", 64'(count), 64'd0);
        chk("rst_mid_ready", 64'(dispatch_ready), 64'd0);
        rst = 1'b1;
        #1;
        chk("rst_mid_ready_after", 64'(dispatch_ready), 64'd1);
        repeat (3) tick();

        check_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
